// File: rtl/par_shift_out.sv
// par_shift_out: parallel-in, serial-out word shifter.
// Takes one L-word vector on a valid/ready handshake and emits it one word
// per beat, oldest first (index L-1 down to 0). It can chain vectors
// back-to-back without a bubble.
//
// Optional feature (compile-time macro PAR_SHIFT_OUT_CNT_EN): adds the s_cnt
// port so a vector may carry fewer than L words. Counts above L are clamped
// to L. A count of 0 completes the handshake and emits nothing.
//
// Ports:
//   clk    - clock
//   rst    - synchronous, active-high reset
//   s_vld  - input vector valid
//   s_rdy  - input vector ready (forced low while rst is high)
//   s_data - input vector; word L-1 is emitted first
//   s_cnt  - number of valid words (only with PAR_SHIFT_OUT_CNT_EN)
//   d_vld  - output word valid
//   d_rdy  - output word ready
//   d_data - output word
//   d_last - high on the final word of a vector
module par_shift_out #(
  parameter int DW = 16,
  parameter int L  = 4,
  parameter int CW = $clog2(L + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_vld,
  output logic                 s_rdy,
  input  logic [L-1:0][DW-1:0] s_data,
`ifdef PAR_SHIFT_OUT_CNT_EN
  input  logic [CW-1:0]        s_cnt,
`endif
  output logic                 d_vld,
  input  logic                 d_rdy,
  output logic [DW-1:0]        d_data,
  output logic                 d_last
);

  localparam int IW = $clog2(L);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state;
  logic [L-1:0][DW-1:0] vec;
  logic [IW-1:0]        idx;
  logic [CW-1:0]        n_words;
  logic [IW-1:0]        idx_first;
  logic                 load;
  logic                 beat;
  logic                 empty_load;

`ifdef PAR_SHIFT_OUT_CNT_EN
  always_comb begin
    n_words = s_cnt;
    if (s_cnt > CW'(L)) n_words = CW'(L);
  end
`else
  assign n_words = CW'(L);
`endif

  assign empty_load = (n_words == '0);
  assign idx_first  = IW'(n_words - CW'(1));

  // Ready is also raised during the final accepted beat so the next vector
  // can load on the same edge and keep the output stream gap-free.
  assign s_rdy = !rst && ((state == IDLE) || (d_vld && d_rdy && d_last));
  assign load  = s_vld && s_rdy;
  assign beat  = d_vld && d_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      vec    <= '0;
      idx    <= '0;
      d_vld  <= 1'b0;
      d_data <= '0;
      d_last <= 1'b0;
    end else if (load && !empty_load) begin
      // Present the first word straight from s_data so it is valid one cycle
      // after the load instead of two.
      vec    <= s_data;
      idx    <= idx_first;
      state  <= SHIFT;
      d_vld  <= 1'b1;
      d_data <= s_data[idx_first];
      d_last <= (n_words == CW'(1));
    end else if (beat) begin
      if (idx != '0) begin
        idx    <= idx - IW'(1);
        d_data <= vec[idx - IW'(1)];
        d_last <= (idx == IW'(1));
      end else begin
        // The final beat is accepted and no non-empty vector arrives behind it.
        state  <= IDLE;
        d_vld  <= 1'b0;
        d_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_par_shift_out.sv
// Testbench for par_shift_out in its default build (L=4, DW=16, no s_cnt).
// A queue of {last, word} entries is the reference. Each accepted vector
// appends its words oldest-first, and each accepted output beat pops the
// front entry. Every cycle the bench compares the DUT against this queue.
module tb_par_shift_out;

  localparam int DW = 16;
  localparam int L  = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 s_vld = 1'b0;
  logic                 s_rdy;
  logic [L-1:0][DW-1:0] s_data = '0;
  logic                 d_vld;
  logic                 d_rdy = 1'b1;
  logic [DW-1:0]        d_data;
  logic                 d_last;

  par_shift_out #(.DW(DW), .L(L)) dut (
    .clk    (clk),
    .rst    (rst),
    .s_vld  (s_vld),
    .s_rdy  (s_rdy),
    .s_data (s_data),
    .d_vld  (d_vld),
    .d_rdy  (d_rdy),
    .d_data (d_data),
    .d_last (d_last)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  logic [DW:0]          q[$];
  logic                 mon_en = 1'b0;
  logic                 s_hs = 1'b0;
  logic                 d_hs = 1'b0;
  logic                 rst_s = 1'b1;
  logic [L-1:0][DW-1:0] s_cap = '0;

  // Sample at the negedge, when the inputs are settled.
  always @(negedge clk) begin
    logic exp_rdy;
    if (mon_en) begin
      check("d_vld", {31'b0, d_vld}, {31'b0, q.size() != 0});
      exp_rdy = !rst && (q.size() == 0 || (q.size() == 1 && d_rdy));
      check("s_rdy", {31'b0, s_rdy}, {31'b0, exp_rdy});
      if (d_vld && q.size() != 0) begin
        check("d_data", {16'b0, d_data}, {16'b0, q[0][DW-1:0]});
        check("d_last", {31'b0, d_last}, {31'b0, q[0][DW]});
      end
    end
    s_hs  = s_vld && s_rdy;
    d_hs  = d_vld && d_rdy;
    rst_s = rst;
    s_cap = s_data;
  end

  // Update the reference model at each clock edge.
  always @(posedge clk) begin
    if (rst_s) q.delete();
    else begin
      if (d_hs && q.size() != 0) void'(q.pop_front());
      if (s_hs)
        for (int i = L - 1; i >= 0; i--) q.push_back({i == 0, s_cap[i]});
    end
  end

  // d_rdy pattern: 0 = always ready, 1 = repeating 1,0,0, 2 = random.
  int mode = 0;
  initial begin
    int pat = 0;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0:       d_rdy = 1'b1;
        1:       begin d_rdy = (pat % 3 == 0); pat++; end
        default: d_rdy = ($urandom % 4) != 0;
      endcase
    end
  end

  task automatic load_vec(input logic [L-1:0][DW-1:0] v);
    logic done = 1'b0;
    s_vld  = 1'b1;
    s_data = v;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      done = s_hs;
      #1;
    end
    if (!done) check("load_timeout", 32'd0, 32'd1);
    s_vld  = 1'b0;
    s_data = {$urandom, $urandom};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    idle(2);
    check("rst_d_vld",  {31'b0, d_vld},  32'd0);
    check("rst_d_data", {16'b0, d_data}, 32'd0);
    check("rst_d_last", {31'b0, d_last}, 32'd0);
    check("rst_s_rdy",  {31'b0, s_rdy},  32'd0);
    rst = 1'b0;
    #1;
    check("idle_s_rdy", {31'b0, s_rdy},  32'd1);
    mon_en = 1'b1;

    // Single vector with d_rdy held high
    load_vec({16'hD, 16'hC, 16'hB, 16'hA});
    idle(6);

    // Two vectors back to back
    load_vec({16'h1114, 16'h1113, 16'h1112, 16'h1111});
    load_vec({16'h2224, 16'h2223, 16'h2222, 16'h2221});
    idle(10);

    // Backpressure with d_rdy = 1,0,0,...
    mode = 1;
    load_vec({16'h3334, 16'h3333, 16'h3332, 16'h3331});
    load_vec({16'h4444, 16'h4443, 16'h4442, 16'h4441});
    idle(30);
    mode = 0;
    idle(3);

    // Reset after two of four beats are accepted
    load_vec({16'h5554, 16'h5553, 16'h5552, 16'h5551});
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    #1;
    check("rst_mid_d_vld", {31'b0, d_vld}, 32'd0);
    check("rst_mid_s_rdy", {31'b0, s_rdy}, 32'd1);
    load_vec({16'h6664, 16'h6663, 16'h6662, 16'h6661});
    idle(8);

    // Random s_vld/d_rdy with occasional reset
    mode = 2;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      rst    = ($urandom % 700) == 0;
      s_vld  = ($urandom % 3) != 0;
      s_data = {$urandom, $urandom};
    end
    rst   = 1'b0;
    s_vld = 1'b0;
    mode  = 0;
    idle(20);
    check("drain_q_empty", q.size(), 32'd0);
    check("drain_d_vld", {31'b0, d_vld}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
